// File: rtl/dcache_if.sv
// Bundle of the pipeline request port and the two line-granular memory
// channels seen by dcache_2way.
//
// Handshakes: a pipeline request is present while req_valid=1 and completes
// in any cycle where stall=0. The cache holds mem_rd_req / mem_wr_req (with
// stable address and data) until it samples mem_rd_ready / mem_wr_ack high
// at a rising edge. Ready/ack outside the matching request are ignored.
interface dcache_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();
    localparam int OFF  = $clog2(LINE_W / 8);
    localparam int LA_W = ADDR_W - OFF;

    logic              req_valid;
    logic              req_write;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rdata;
    logic              stall;

    logic              mem_rd_req;
    logic [LA_W-1:0]   mem_rd_addr;
    logic [LINE_W-1:0] mem_rd_data;
    logic              mem_rd_ready;

    logic              mem_wr_req;
    logic [LA_W-1:0]   mem_wr_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_wr_ack;

    // Cache side.
    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata,
        output req_rdata, stall,
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_data, mem_rd_ready,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_wr_ack
    );

    // Pipeline / memory side.
    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata,
        input  req_rdata, stall,
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_data, mem_rd_ready,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_wr_ack
    );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with one LRU
// bit per set. Hits complete in the same cycle; misses stall the pipeline
// through an optional victim write-back and a line refill.
module dcache_2way #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int SETS   = 4
) (
    input  logic       clk,
    input  logic       reset,
    dcache_if.slave    bus,
    output logic [1:0] state_dbg
);
    localparam int OFF  = $clog2(LINE_W / 8);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_W - OFF - IDX;
    localparam int LA_W = ADDR_W - OFF;

    typedef enum logic [1:0] {IDLE = 2'd0, WBACK = 2'd1, REFILL = 2'd2} state_t;

    state_t state;

    logic [SETS-1:0]   valid [2];
    logic [SETS-1:0]   dirty [2];
    logic [SETS-1:0]   lru;
    logic [TAG-1:0]    tag_mem  [2][SETS];
    logic [LINE_W-1:0] data_mem [2][SETS];

    // Miss bookkeeping, latched in the IDLE miss cycle so the fill completes
    // even if the pipeline drops its request.
    logic              vic_q;
    logic [IDX-1:0]    fill_idx_q;
    logic [TAG-1:0]    fill_tag_q;
    logic              rd_req_q;
    logic [LA_W-1:0]   rd_addr_q;
    logic              wr_req_q;
    logic [LA_W-1:0]   wr_addr_q;
    logic [LINE_W-1:0] wr_data_q;

    // Request decode.
    logic [IDX-1:0]    idx;
    logic [TAG-1:0]    tag;
    logic [OFF+2:0]    word_bit;
    logic [OFF+2:0]    byte_bit;
    logic [1:0]        hit_way;
    logic              hit;
    logic              hw;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic              vic;
    logic              vic_dirty;
    logic              in_idle_req;

    assign idx      = bus.req_addr[OFF+IDX-1:OFF];
    assign tag      = bus.req_addr[ADDR_W-1:OFF+IDX];
    assign word_bit = {bus.req_addr[OFF-1:2], 5'b0};
    assign byte_bit = {bus.req_addr[OFF-1:0], 3'b0};

    assign hit_way[0] = valid[0][idx] && (tag_mem[0][idx] == tag);
    assign hit_way[1] = valid[1][idx] && (tag_mem[1][idx] == tag);
    assign hit        = |hit_way;
    assign hw         = hit_way[1];
    assign hit_line   = data_mem[hw][idx];
    assign rd_word    = hit_line[word_bit +: 32];
    assign rd_byte    = hit_line[byte_bit +: 8];

    // Fill an empty way first, otherwise evict the least recently used one.
    assign vic       = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
    assign vic_dirty = valid[vic][idx] && dirty[vic][idx];

    assign in_idle_req = (state == IDLE) && bus.req_valid;

    // Store merge of a byte or word into the hit line.
    always_comb begin
        merged = hit_line;
        if (bus.req_byte) merged[byte_bit +: 8]  = bus.req_wdata[7:0];
        else              merged[word_bit +: 32] = bus.req_wdata;
    end

    // Load data and stall; stall drops at once while reset is asserted.
    always_comb begin
        bus.req_rdata = '0;
        if (in_idle_req && hit && !bus.req_write)
            bus.req_rdata = bus.req_byte ? {24'b0, rd_byte} : rd_word;
        bus.stall = !reset && ((state != IDLE) || (bus.req_valid && !hit));
    end

    assign bus.mem_rd_req  = rd_req_q;
    assign bus.mem_rd_addr = rd_req_q ? rd_addr_q : '0;
    assign bus.mem_wr_req  = wr_req_q;
    assign bus.mem_wr_addr = wr_req_q ? wr_addr_q : '0;
    assign bus.mem_wr_data = wr_req_q ? wr_data_q : '0;
    assign state_dbg       = state;

    // Miss FSM with registered memory requests, plus valid/dirty/lru tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid[0]   <= '0;
            valid[1]   <= '0;
            dirty[0]   <= '0;
            dirty[1]   <= '0;
            lru        <= '0;
            vic_q      <= 1'b0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && hit) begin
                        lru[idx] <= ~hw;
                        if (bus.req_write) dirty[hw][idx] <= 1'b1;
                    end else if (bus.req_valid) begin
                        vic_q      <= vic;
                        fill_idx_q <= idx;
                        fill_tag_q <= tag;
                        rd_addr_q  <= bus.req_addr[ADDR_W-1:OFF];
                        if (vic_dirty) begin
                            state     <= WBACK;
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= {tag_mem[vic][idx], idx};
                            wr_data_q <= data_mem[vic][idx];
                        end else begin
                            state    <= REFILL;
                            rd_req_q <= 1'b1;
                        end
                    end
                end
                WBACK: begin
                    if (bus.mem_wr_ack) begin
                        state    <= REFILL;
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b1;
                    end
                end
                REFILL: begin
                    if (bus.mem_rd_ready) begin
                        state                    <= IDLE;
                        rd_req_q                 <= 1'b0;
                        valid[vic_q][fill_idx_q] <= 1'b1;
                        dirty[vic_q][fill_idx_q] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: store hits merge in place, refills install a line.
    always_ff @(posedge clk) begin
        if (in_idle_req && hit && bus.req_write) begin
            data_mem[hw][idx] <= merged;
        end else if (state == REFILL && bus.mem_rd_ready) begin
            data_mem[vic_q][fill_idx_q] <= bus.mem_rd_data;
            tag_mem[vic_q][fill_idx_q]  <= fill_tag_q;
        end
    end
endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised 2-way set-associative, write-back, write-allocate data cache for the memory stage of the pipeline. It sits between the ALU/memory pipeline registers and the line-granular main-memory model, replacing the fixed direct-mapped cache stage. It adds configurable set count, LRU replacement, byte/word access and a single `stall` output that freezes the pipeline on a miss. Memory traffic uses full lines through separate read and write request/acknowledge channels.

## Interface
- `ADDR_W`, 32, byte-address width
- `LINE_W`, 128, line width in bits (power of two, ≥ 64)
- `SETS`, 4, number of sets (power of two, ≥ 2)
- Derived: `OFF = log2(LINE_W/8)`, `IDX = log2(SETS)`, `TAG = ADDR_W-OFF-IDX`, `LA_W = ADDR_W-OFF`
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  load/store present this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_byte`  in  1  1 = byte access, 0 = 32-bit word access
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data (byte stores use bits [7:0])
- `req_rdata`  out  32  load data, valid when `req_valid & !req_write & !stall`
- `stall`  out  1  request not complete; pipeline holds all request inputs
- `mem_rd_req`  out  1  line fill request
- `mem_rd_addr`  out  LA_W  line address (`req_addr[ADDR_W-1:OFF]`)
- `mem_rd_data`  in  LINE_W  fill data
- `mem_rd_ready`  in  1  fill data valid
- `mem_wr_req`  out  1  victim write-back request
- `mem_wr_addr`  out  LA_W  victim line address `{tag, index}`
- `mem_wr_data`  out  LINE_W  victim line
- `mem_wr_ack`  in  1  write-back accepted

## Operation
- Per way and set: `valid`, `dirty`, `tag`, LINE_W data. Per set: one `lru` bit naming the least-recently-used way.
- Index = `req_addr[OFF+IDX-1:OFF]`. Word select = `req_addr[OFF-1:2]`. Byte select = `req_addr[OFF-1:0]`. Little-endian: word k is line bits [32k+31:32k]. `req_addr[1:0]` is ignored for word access.
- Byte loads zero-extend into `req_rdata`. `req_rdata` = 0 when there is no hit.
- Hit = `valid & tag match` in either way. A match in both ways is illegal.
- FSM states: IDLE, WBACK, REFILL.
- IDLE, `req_valid` & hit: `stall`=0. A load returns data combinationally. A store merges the byte/word at the edge and sets `dirty`. `lru` is set to the other way.
- IDLE, `req_valid` & miss: `stall`=1. Victim is way 0 if invalid, else way 1 if invalid, else `lru`. Next state is WBACK if the victim is valid & dirty, else REFILL. The victim way is latched.
- WBACK: `mem_wr_req`=1 with stable address and data until `mem_wr_ack`=1 is sampled, then go to REFILL.
- REFILL: `mem_rd_req`=1 until `mem_rd_ready`=1 is sampled. Then write `mem_rd_data` into the victim: valid=1, dirty=0, tag updated. Return to IDLE. The held request then hits on the next cycle.
- `stall`=1 throughout WBACK and REFILL, and in the IDLE miss cycle.
- `mem_rd_ready` outside REFILL and `mem_wr_ack` outside WBACK are ignored.
- If `req_valid` drops mid-miss, the sequence still completes and no store is applied.
- `req_valid`=0 in IDLE: no state change, `stall`=0.

## Timing
- Reset (async): all `valid`, `dirty`, `lru` = 0; state = IDLE. `stall`, `mem_rd_req`, `mem_wr_req` = 0. `mem_*_addr`, `mem_wr_data`, `req_rdata` = 0.
- Outputs are 0 whenever not in their request state.
- Reset during WBACK or REFILL aborts the transaction immediately. Requests drop in the same cycle and a partial line is never installed.
- Hit latency: 0 cycles (combinational data, store committed at the edge).
- Clean miss: 1 (IDLE) + N_rd cycles in REFILL + 1 hit cycle.
- Dirty miss: adds N_wr cycles of WBACK.
- `mem_rd_ready` and `mem_wr_ack` may arrive in the first cycle of their state (minimum 1 cycle per state).

## Test plan
Defaults: SETS=4, LINE_W=128. Addresses 0x100, 0x200 and 0x300 all map to index 0.

- **Cold miss then refill.** Reset, load 0x104, `mem_rd_data`=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, ready after 2 cycles -> `mem_rd_addr`=0x0000010, `stall` high for 3 cycles, then `req_rdata`=0xCCCCCCCC with `stall`=0.
- **Two ways coexist.** Load 0x200 after 0x100 -> the second miss fills way 1. Loads of 0x100 and 0x200 then both hit with no memory request.
- **LRU eviction with write-back.** Store word 0x11223344 to 0x100, load 0x200, then load 0x300 -> WBACK with `mem_wr_addr`=0x0000010 and word 0 of `mem_wr_data`=0x11223344. REFILL of 0x0000030 follows.
- **Byte access.** Store byte 0x5A to 0x107 (line resident) -> a word load at 0x104 returns 0x5Axxxxxx with the other bytes unchanged. A byte load at 0x107 returns 0x0000005A.
- **Reset mid-refill.** Assert `reset` in the second REFILL cycle -> `mem_rd_req` and `stall` drop immediately. A subsequent load of the same address misses again.
- **Spurious handshakes.** Pulse `mem_rd_ready` and `mem_wr_ack` while idle -> no state or array change.
